// File: rtl/batcharger_ctrl_fsm.sv
// batcharger_ctrl_fsm: TC/CC/CV Li-ion charge controller with termination, recharge, safety timers and fault latching.
// Ports: clk_i/rst_ni clock and async active-low reset; en_i enable; sel_i capacity select (50 mAh*(sel+1));
//   sample_valid_i strobe qualifying vbat_i/ibat_i/vtemp_i ADC codes; tc_o/cc_o/cv_o one-hot mode flags;
//   done_o charge complete; fault_o latched fault; iset_o/vset_o current/voltage DAC setpoints.
// Build option: define TEMP_PROT_EN to fault on vtemp outside [TLOW, THIGH] while charging.
module batcharger_ctrl_fsm #(
    parameter int ADC_W       = 10,
    parameter int VCUTOFF     = 600,
    parameter int VTARGET     = 840,
    parameter int VRECHG      = 800,
    parameter int ICC_STEP    = 16,
    parameter int END_CNT     = 4,
    parameter int TMR_W       = 16,
    parameter int TC_TIMEOUT  = 1024,
    parameter int CHG_TIMEOUT = 65535,
    parameter int TLOW        = 100,
    parameter int THIGH       = 400
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [3:0]       sel_i,
    input  logic             sample_valid_i,
    input  logic [ADC_W-1:0] vbat_i,
    input  logic [ADC_W-1:0] ibat_i,
    input  logic [ADC_W-1:0] vtemp_i,
    output logic             tc_o,
    output logic             cc_o,
    output logic             cv_o,
    output logic             done_o,
    output logic             fault_o,
    output logic [ADC_W-1:0] iset_o,
    output logic [ADC_W-1:0] vset_o
);
    typedef enum logic [2:0] {S_IDLE, S_TC, S_CC, S_CV, S_DONE, S_FAULT} state_e;
    localparam int IMAX = (1 << ADC_W) - 1;
    localparam int EC_W = $clog2(END_CNT + 1);
    state_e            state_q, state_d;
    logic [TMR_W-1:0]  tc_tmr_q, tc_tmr_d, chg_tmr_q, chg_tmr_d, tc_inc, chg_inc;
    logic [EC_W-1:0]   end_cnt_q, end_cnt_d, ec_inc;
    logic [ADC_W-1:0]  iset_q, iset_d, icc, itc, iend;
    logic [31:0]       icc_w;
    logic              temp_bad, tc_exp, chg_exp;
    assign icc_w = (32'(sel_i) + 32'd1) * 32'(ICC_STEP);
    assign icc   = (icc_w > 32'(IMAX)) ? ADC_W'(IMAX) : icc_w[ADC_W-1:0];
    assign itc   = icc >> 3;
    assign iend  = icc >> 4;
`ifdef TEMP_PROT_EN
    assign temp_bad = (vtemp_i < ADC_W'(TLOW)) || (vtemp_i > ADC_W'(THIGH));
`else
    logic unused_vtemp;
    assign unused_vtemp = ^vtemp_i;
    assign temp_bad     = 1'b0;
`endif
    // Saturating increments so a timer parked at its ceiling never wraps back to zero.
    assign tc_inc  = (&tc_tmr_q) ? tc_tmr_q : tc_tmr_q + 1'b1;
    assign chg_inc = (&chg_tmr_q) ? chg_tmr_q : chg_tmr_q + 1'b1;
    assign ec_inc  = (end_cnt_q == EC_W'(END_CNT)) ? end_cnt_q : end_cnt_q + 1'b1;
    assign tc_exp  = tc_inc >= TMR_W'(TC_TIMEOUT);
    assign chg_exp = chg_inc >= TMR_W'(CHG_TIMEOUT);
    always_comb begin
        state_d   = state_q;
        tc_tmr_d  = tc_tmr_q;
        chg_tmr_d = chg_tmr_q;
        end_cnt_d = end_cnt_q;
        if (!en_i) begin
            state_d   = S_IDLE;
            tc_tmr_d  = '0;
            chg_tmr_d = '0;
            end_cnt_d = '0;
        end else if (sample_valid_i) begin
            case (state_q)
                S_IDLE: state_d = (vbat_i < ADC_W'(VCUTOFF)) ? S_TC :
                                  (vbat_i < ADC_W'(VTARGET)) ? S_CC : S_CV;
                S_TC: begin
                    tc_tmr_d = tc_inc;
                    state_d  = (temp_bad || tc_exp) ? S_FAULT :
                               (vbat_i >= ADC_W'(VCUTOFF)) ? S_CC : S_TC;
                end
                S_CC: begin
                    chg_tmr_d = chg_inc;
                    state_d   = (temp_bad || chg_exp) ? S_FAULT :
                                (vbat_i >= ADC_W'(VTARGET)) ? S_CV : S_CC;
                end
                S_CV: begin
                    chg_tmr_d = chg_inc;
                    end_cnt_d = (ibat_i < iend) ? ec_inc : '0;
                    state_d   = (temp_bad || chg_exp) ? S_FAULT :
                                (end_cnt_d == EC_W'(END_CNT)) ? S_DONE : S_CV;
                end
                S_DONE: begin
                    if (temp_bad) begin
                        state_d = S_FAULT;
                    end else if (vbat_i < ADC_W'(VRECHG)) begin
                        state_d   = S_CC;
                        chg_tmr_d = '0;
                        end_cnt_d = '0;
                    end
                end
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_IDLE;
            endcase
        end
    end
    // iset is latched only on a sample (or disable) so a sel change waits for the next sample.
    assign iset_d = (state_d == S_TC) ? itc :
                    (state_d == S_CC || state_d == S_CV) ? icc : '0;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            tc_tmr_q  <= '0;
            chg_tmr_q <= '0;
            end_cnt_q <= '0;
            iset_q    <= '0;
        end else begin
            state_q   <= state_d;
            tc_tmr_q  <= tc_tmr_d;
            chg_tmr_q <= chg_tmr_d;
            end_cnt_q <= end_cnt_d;
            if (!en_i || sample_valid_i) iset_q <= iset_d;
        end
    end
    assign tc_o    = state_q == S_TC;
    assign cc_o    = state_q == S_CC;
    assign cv_o    = state_q == S_CV;
    assign done_o  = state_q == S_DONE;
    assign fault_o = state_q == S_FAULT;
    assign iset_o  = iset_q;
    assign vset_o  = (tc_o || cc_o || cv_o) ? ADC_W'(VTARGET) : '0;
endmodule

// File: tb/tb_batcharger_ctrl_fsm.sv
// tb_batcharger_ctrl_fsm: scenario and randomized checks of batcharger_ctrl_fsm against a behavioural charge model.
module tb_batcharger_ctrl_fsm;
    localparam int CHG_TO = 300;
    localparam int M_IDLE = 0, M_TC = 1, M_CC = 2, M_CV = 3, M_DONE = 4, M_FAULT = 5;
    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, sv = 1'b0;
    logic [3:0]  sel = 4'd7;
    logic [9:0]  vbat = '0, ibat = '0, vtemp = 10'd250;
    logic        tc_o, cc_o, cv_o, done_o, fault_o;
    logic [9:0]  iset_o, vset_o;
    logic [24:0] obs;
    int          n_chk = 0, n_pass = 0;
    int          m_mode = M_IDLE, m_tcn = 0, m_chg = 0, m_low = 0, m_iset = 0;

    batcharger_ctrl_fsm #(.CHG_TIMEOUT(CHG_TO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .sel_i(sel), .sample_valid_i(sv),
        .vbat_i(vbat), .ibat_i(ibat), .vtemp_i(vtemp),
        .tc_o(tc_o), .cc_o(cc_o), .cv_o(cv_o), .done_o(done_o), .fault_o(fault_o),
        .iset_o(iset_o), .vset_o(vset_o)
    );

    always #5 clk = ~clk;
    assign obs = {tc_o, cc_o, cv_o, done_o, fault_o, iset_o, vset_o};

    function automatic logic [24:0] exp_vec();
        logic charging;
        charging = m_mode == M_TC || m_mode == M_CC || m_mode == M_CV;
        return {m_mode == M_TC, m_mode == M_CC, m_mode == M_CV, m_mode == M_DONE,
                m_mode == M_FAULT, 10'(m_iset), charging ? 10'd840 : 10'd0};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_tcn = 0; m_chg = 0; m_low = 0; m_iset = 0;
    endtask

    // Charging rules applied once per clock edge to the inputs present at that edge.
    task automatic model_step();
        int  icc;
        bit  hot;
        icc = (int'(sel) + 1) * 16;
        if (icc > 1023) icc = 1023;
`ifdef TEMP_PROT_EN
        hot = int'(vtemp) < 100 || int'(vtemp) > 400;
`else
        hot = 1'b0;
`endif
        if (!en) begin
            model_reset();
        end else if (sv) begin
            case (m_mode)
                M_IDLE: m_mode = int'(vbat) < 600 ? M_TC : int'(vbat) < 840 ? M_CC : M_CV;
                M_TC: begin
                    m_tcn++;
                    if (hot || m_tcn >= 1024) m_mode = M_FAULT;
                    else if (int'(vbat) >= 600) m_mode = M_CC;
                end
                M_CC: begin
                    m_chg++;
                    if (hot || m_chg >= CHG_TO) m_mode = M_FAULT;
                    else if (int'(vbat) >= 840) m_mode = M_CV;
                end
                M_CV: begin
                    m_chg++;
                    m_low = int'(ibat) < icc / 16 ? m_low + 1 : 0;
                    if (hot || m_chg >= CHG_TO) m_mode = M_FAULT;
                    else if (m_low >= 4) m_mode = M_DONE;
                end
                M_DONE: begin
                    if (hot) m_mode = M_FAULT;
                    else if (int'(vbat) < 800) begin m_mode = M_CC; m_chg = 0; m_low = 0; end
                end
                default: ;
            endcase
            m_iset = m_mode == M_TC ? icc / 8 : (m_mode == M_CC || m_mode == M_CV) ? icc : 0;
        end
    endtask

    task automatic cyc(input logic e, input logic s, input int vb, input int ib, input int vt);
        en = e; sv = s; vbat = 10'(vb); ibat = 10'(ib); vtemp = 10'(vt);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_chk++; if (obs !== 25'd0) $display("FAIL reset_async: got %h exp 0", obs); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (obs !== 25'd0) $display("FAIL reset_hold: got %h exp 0", obs); else n_pass++;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_tc_cc();
        sel = 4'd7;
        cyc(1, 1, 500, 50, 250);
        n_chk++; if ({tc_o, cc_o, iset_o, vset_o} !== {1'b1, 1'b0, 10'd16, 10'd840})
            $display("FAIL tc_entry: got tc=%b cc=%b iset=%0d vset=%0d exp tc=1 iset=16 vset=840", tc_o, cc_o, iset_o, vset_o); else n_pass++;
        cyc(1, 1, 650, 50, 250);
        n_chk++; if ({tc_o, cc_o, iset_o} !== {1'b0, 1'b1, 10'd128})
            $display("FAIL cc_entry: got tc=%b cc=%b iset=%0d exp cc=1 iset=128", tc_o, cc_o, iset_o); else n_pass++;
    endtask

    task automatic test_cv_done();
        cyc(1, 1, 840, 50, 250);
        n_chk++; if ({cc_o, cv_o} !== 2'b01) $display("FAIL cv_entry: got cc=%b cv=%b exp cv=1", cc_o, cv_o); else n_pass++;
        for (int i = 0; i < 3; i++) cyc(1, 1, 845, 7, 250);
        cyc(1, 1, 845, 50, 250);
        n_chk++; if ({cv_o, done_o} !== 2'b10) $display("FAIL cv_broken_run: got cv=%b done=%b exp cv=1 done=0", cv_o, done_o); else n_pass++;
        for (int i = 0; i < 3; i++) cyc(1, 1, 845, 7, 250);
        n_chk++; if ({cv_o, done_o} !== 2'b10) $display("FAIL cv_three_low: got cv=%b done=%b exp cv=1 done=0", cv_o, done_o); else n_pass++;
        cyc(1, 1, 845, 7, 250);
        n_chk++; if ({cv_o, done_o, iset_o} !== {1'b0, 1'b1, 10'd0})
            $display("FAIL done_entry: got cv=%b done=%b iset=%0d exp done=1 iset=0", cv_o, done_o, iset_o); else n_pass++;
        cyc(1, 1, 810, 7, 250);
        n_chk++; if (obs !== exp_vec()) $display("FAIL done_hold: got %h exp %h", obs, exp_vec()); else n_pass++;
    endtask

    task automatic test_recharge();
        cyc(1, 1, 790, 50, 250);
        n_chk++; if ({done_o, cc_o, iset_o} !== {1'b0, 1'b1, 10'd128})
            $display("FAIL recharge: got done=%b cc=%b iset=%0d exp cc=1 iset=128", done_o, cc_o, iset_o); else n_pass++;
        for (int i = 0; i < CHG_TO - 1; i++) cyc(1, 1, 700, 50, 250);
        n_chk++; if ({cc_o, fault_o} !== 2'b10) $display("FAIL chg_tmr_restart: got cc=%b fault=%b exp cc=1 fault=0", cc_o, fault_o); else n_pass++;
        cyc(1, 1, 700, 50, 250);
        n_chk++; if ({cc_o, fault_o, iset_o} !== {1'b0, 1'b1, 10'd0})
            $display("FAIL chg_timeout: got cc=%b fault=%b iset=%0d exp fault=1 iset=0", cc_o, fault_o, iset_o); else n_pass++;
        cyc(1, 1, 500, 50, 250);
        n_chk++; if (fault_o !== 1'b1) $display("FAIL fault_sticky: got fault=%b exp 1", fault_o); else n_pass++;
    endtask

    task automatic test_tc_timeout();
        cyc(0, 0, 0, 0, 250);
        cyc(1, 1, 500, 50, 250);
        for (int i = 0; i < 1023; i++) cyc(1, 1, 500, 50, 250);
        n_chk++; if ({tc_o, fault_o} !== 2'b10) $display("FAIL tc_pre_timeout: got tc=%b fault=%b exp tc=1 fault=0", tc_o, fault_o); else n_pass++;
        cyc(1, 1, 500, 50, 250);
        n_chk++; if ({tc_o, fault_o} !== 2'b01) $display("FAIL tc_timeout: got tc=%b fault=%b exp tc=0 fault=1", tc_o, fault_o); else n_pass++;
        cyc(0, 0, 500, 50, 250);
        n_chk++; if (obs !== 25'd0) $display("FAIL fault_clear: got %h exp 0", obs); else n_pass++;
    endtask

    task automatic test_en_drop();
        cyc(1, 1, 850, 50, 250);
        n_chk++; if ({cv_o, iset_o} !== {1'b1, 10'd128}) $display("FAIL idle_to_cv: got cv=%b iset=%0d exp cv=1 iset=128", cv_o, iset_o); else n_pass++;
        cyc(0, 0, 850, 50, 250);
        n_chk++; if (obs !== 25'd0) $display("FAIL en_drop: got %h exp 0", obs); else n_pass++;
    endtask

    task automatic test_sel_change();
        sel = 4'd7;
        cyc(1, 1, 650, 50, 250);
        sel = 4'd3;
        cyc(1, 0, 650, 50, 250);
        n_chk++; if ({cc_o, iset_o} !== {1'b1, 10'd128}) $display("FAIL sel_no_sample: got cc=%b iset=%0d exp cc=1 iset=128", cc_o, iset_o); else n_pass++;
        cyc(1, 1, 650, 50, 250);
        n_chk++; if ({cc_o, iset_o} !== {1'b1, 10'd64}) $display("FAIL sel_sample: got cc=%b iset=%0d exp cc=1 iset=64", cc_o, iset_o); else n_pass++;
    endtask

    task automatic test_temp();
        cyc(1, 1, 650, 50, 450);
`ifdef TEMP_PROT_EN
        n_chk++; if ({cc_o, fault_o} !== 2'b01) $display("FAIL temp_fault: got cc=%b fault=%b exp fault=1", cc_o, fault_o); else n_pass++;
`else
        n_chk++; if ({cc_o, fault_o} !== 2'b10) $display("FAIL temp_ignored: got cc=%b fault=%b exp cc=1", cc_o, fault_o); else n_pass++;
`endif
        cyc(0, 0, 650, 50, 250);
    endtask

    task automatic test_async_reset();
        cyc(1, 1, 650, 50, 250);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        n_chk++; if (obs !== 25'd0) $display("FAIL async_reset: got %h exp 0", obs); else n_pass++;
        #2 rst_n = 1'b1;
        cyc(1, 1, 500, 50, 250);
        n_chk++; if (obs !== exp_vec()) $display("FAIL post_reset: got %h exp %h", obs, exp_vec()); else n_pass++;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) sel = 4'($urandom_range(0, 15));
            cyc($urandom_range(0, 59) != 0, 1'($urandom_range(0, 1)), $urandom_range(450, 900),
                $urandom_range(0, 24), $urandom_range(0, 19) == 0 ? $urandom_range(0, 600) : 250);
            n_chk++;
            if (obs !== exp_vec()) begin
                errs++;
                if (errs <= 10) $display("FAIL random[%0d]: got %h exp %h", i, obs, exp_vec());
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_tc_cc();
        test_cv_done();
        test_recharge();
        test_tc_timeout();
        test_en_drop();
        test_sel_change();
        test_temp();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
